// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: one slave port shared by master_count masters, whole CYC bursts per grant.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
  parameter int adr_width      = 32,
  parameter int dat_width      = 32,
  parameter int sel_width      = dat_width / 8,
  parameter int master_count   = 2,
  parameter int timeout_cycles = 255
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [master_count*adr_width-1:0]   wb_m_adr,
  input  logic [master_count*dat_width-1:0]   wb_m_datwr,
  output logic [master_count*dat_width-1:0]   wb_m_datrd,
  input  logic [master_count-1:0]             wb_m_we,
  input  logic [master_count-1:0]             wb_m_stb,
  output logic [master_count-1:0]             wb_m_ack,
  output logic [master_count-1:0]             wb_m_err,
  input  logic [master_count-1:0]             wb_m_cyc,
  input  logic [master_count*sel_width-1:0]   wb_m_sel,
  output logic [adr_width-1:0]                wb_s_adr,
  output logic [dat_width-1:0]                wb_s_datwr,
  input  logic [dat_width-1:0]                wb_s_datrd,
  output logic                                wb_s_we,
  output logic                                wb_s_stb,
  input  logic                                wb_s_ack,
  output logic                                wb_s_cyc,
  output logic [sel_width-1:0]                wb_s_sel,
  output logic [master_count-1:0]             grant
);

  localparam int IW = (master_count > 1) ? $clog2(master_count) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state_q;
  logic [master_count-1:0] grant_q;
  logic [IW-1:0]           gidx_q;
  logic [IW-1:0]           last_q;

  logic [adr_width-1:0] m_adr   [master_count];
  logic [dat_width-1:0] m_datwr [master_count];
  logic [sel_width-1:0] m_sel   [master_count];

  genvar gi;
  generate
    for (gi = 0; gi < master_count; gi++) begin : g_slice
      assign m_adr[gi]   = wb_m_adr[gi*adr_width +: adr_width];
      assign m_datwr[gi] = wb_m_datwr[gi*dat_width +: dat_width];
      assign m_sel[gi]   = wb_m_sel[gi*sel_width +: sel_width];
    end
  endgenerate

  // Rotating search: the lowest offset from last_q+1 wins, so scan offsets from far to near.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand_idx;
  int unsigned   cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = master_count; i >= 1; i--) begin
      cand     = (int'(last_q) + i) % master_count;
      cand_idx = IW'(cand);
      if (wb_m_cyc[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  logic busy;
  logic g_cyc;
  logic stb_raw;
  logic timeout_hit;

  assign busy    = (state_q == BUSY);
  assign g_cyc   = wb_m_cyc[gidx_q];
  assign stb_raw = busy & g_cyc & wb_m_stb[gidx_q];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(timeout_cycles + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = busy & (cnt_q == CW'(timeout_cycles));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy || !g_cyc || wb_s_ack || timeout_hit) begin
      cnt_d = '0;
    end else if (stb_raw) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign wb_s_cyc   = busy & g_cyc;
  assign wb_s_stb   = stb_raw & ~timeout_hit;
  assign wb_s_adr   = busy ? m_adr[gidx_q]   : '0;
  assign wb_s_datwr = busy ? m_datwr[gidx_q] : '0;
  assign wb_s_sel   = busy ? m_sel[gidx_q]   : '0;
  assign wb_s_we    = busy & wb_m_we[gidx_q];
  assign grant      = grant_q;

  generate
    for (gi = 0; gi < master_count; gi++) begin : g_ret
      assign wb_m_ack[gi] = grant_q[gi] & wb_s_ack & wb_s_stb;
      assign wb_m_err[gi] = grant_q[gi] & timeout_hit;
      assign wb_m_datrd[gi*dat_width +: dat_width] = grant_q[gi] ? wb_s_datrd : '0;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(master_count - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= BUSY;
            grant_q <= {{(master_count-1){1'b0}}, 1'b1} << pick_idx;
            gidx_q  <= pick_idx;
          end
        end
        BUSY: begin
          // Owner keeps the bus until its cyc drops; the release edge forces one idle cycle.
          if (!g_cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two masters and a small wait-state slave model.
module tb_wb_arbiter;
  logic        clock = 1'b0;
  logic        rst_n;
  logic [63:0] m_adr, m_datwr, m_datrd;
  logic [1:0]  m_we, m_stb, m_ack, m_err, m_cyc, grant;
  logic [7:0]  m_sel;
  logic [31:0] s_adr, s_datwr, s_datrd;
  logic        s_we, s_stb, s_ack, s_cyc;
  logic [3:0]  s_sel;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   slave_en;
  bit   stray_ack;
  int   scnt;
  logic [31:0] slave_data;

  always #5 clock = ~clock;

  wb_arbiter #(
    .adr_width(32), .dat_width(32), .sel_width(4), .master_count(2), .timeout_cycles(8)
  ) dut (
    .clock(clock), .reset(rst_n),
    .wb_m_adr(m_adr), .wb_m_datwr(m_datwr), .wb_m_datrd(m_datrd),
    .wb_m_we(m_we), .wb_m_stb(m_stb), .wb_m_ack(m_ack), .wb_m_err(m_err),
    .wb_m_cyc(m_cyc), .wb_m_sel(m_sel),
    .wb_s_adr(s_adr), .wb_s_datwr(s_datwr), .wb_s_datrd(s_datrd),
    .wb_s_we(s_we), .wb_s_stb(s_stb), .wb_s_ack(s_ack), .wb_s_cyc(s_cyc),
    .wb_s_sel(s_sel), .grant(grant)
  );

  // Slave: two wait cycles after stb is seen, then a one-cycle ack.
  assign s_datrd = slave_data;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      scnt  <= 0;
    end else if (slave_en && s_stb && !s_ack) begin
      if (scnt == 2) begin
        s_ack <= 1'b1;
        scnt  <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
      scnt  <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic mi, input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (m_ack[~mi]) stray_ack = 1'b1;
      if (m_ack[mi]) got = 1'b1;
    end
    n_cmp++;
    assert (got) else begin
      n_bad++;
      $error("FAIL %s: ack observed 0 expected 1 within 40 cycles", tag);
    end
  endtask

  task automatic wait_grant(input string tag);
    for (int c = 0; c < 10 && grant == 2'b00; c++) @(negedge clock);
    n_cmp++;
    assert (grant != 2'b00) else begin
      n_bad++;
      $error("FAIL %s: grant observed 00 expected nonzero within 10 cycles", tag);
    end
  endtask

  task automatic drop(input logic mi);
    m_cyc[mi] = 1'b0;
    m_stb[mi] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gm;
    rst_n = 1'b0; slave_en = 1'b1; stray_ack = 1'b0; slave_data = 32'hCAFEF00D;
    m_adr = '0; m_datwr = '0; m_we = '0; m_stb = '0; m_cyc = '0; m_sel = '0;
    repeat (2) @(negedge clock);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_s_cyc", 64'(s_cyc), 64'(0));
    chk("rst_s_stb", 64'(s_stb), 64'(0));
    chk("rst_s_adr", 64'(s_adr), 64'(0));
    chk("rst_m_ack", 64'(m_ack), 64'(0));
    chk("rst_m_err", 64'(m_err), 64'(0));
    chk("rst_m_datrd", m_datrd, 64'(0));
    rst_n = 1'b1;
    @(negedge clock);

    // single master read
    m_adr[31:0] = 32'h100; m_sel[3:0] = 4'hF; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1 chk("t1_pre_cyc", 64'(s_cyc), 64'(0));
    @(negedge clock);
    chk("t1_grant", 64'(grant), 64'(2'b01));
    chk("t1_s_cyc", 64'(s_cyc), 64'(1));
    chk("t1_s_adr", 64'(s_adr), 64'(32'h100));
    chk("t1_s_sel", 64'(s_sel), 64'(4'hF));
    wait_ack(1'b0, "t1_wait");
    chk("t1_ack", 64'(m_ack), 64'(2'b01));
    chk("t1_datrd", m_datrd, 64'h0000_0000_CAFE_F00D);
    drop(1'b0);
    #1 chk("t1_rel_cyc", 64'(s_cyc), 64'(0));
    @(negedge clock);
    chk("t1_idle_grant", 64'(grant), 64'(0));

    // simultaneous request straight out of reset
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    m_adr = {32'h300, 32'h200}; m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clock);
    chk("t2_grant0", 64'(grant), 64'(2'b01));
    chk("t2_adr0", 64'(s_adr), 64'(32'h200));
    wait_ack(1'b0, "t2_wait0");
    chk("t2_ack0", 64'(m_ack), 64'(2'b01));
    drop(1'b0);
    @(negedge clock);
    chk("t2_gap_grant", 64'(grant), 64'(0));
    chk("t2_gap_cyc", 64'(s_cyc), 64'(0));
    @(negedge clock);
    chk("t2_grant1", 64'(grant), 64'(2'b10));
    chk("t2_adr1", 64'(s_adr), 64'(32'h300));
    wait_ack(1'b1, "t2_wait1");
    chk("t2_datrd1", m_datrd, 64'hCAFE_F00D_0000_0000);
    drop(1'b1);
    @(negedge clock);
    chk("t2_idle", 64'(grant), 64'(0));

    // fairness: both keep requesting, six single transfers
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int t = 0; t < 6; t++) begin
      gm = (t % 2 != 0);
      wait_grant("t3_wait_grant");
      chk($sformatf("t3_grant_%0d", t), 64'(grant), gm ? 64'(2'b10) : 64'(2'b01));
      wait_ack(gm, "t3_wait_ack");
      drop(gm);
      if (t == 5) begin
        m_cyc = 2'b00; m_stb = 2'b00;
      end
      @(negedge clock);
      if (t != 5) begin
        m_cyc[gm] = 1'b1; m_stb[gm] = 1'b1;
      end
    end

    // burst lock: m0 holds four beats while m1 waits
    m_adr[31:0] = 32'h400; m_datwr[31:0] = 32'h1234_5678; m_we[0] = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clock);
    chk("t4_grant0", 64'(grant), 64'(2'b01));
    chk("t4_we", 64'(s_we), 64'(1));
    chk("t4_datwr", 64'(s_datwr), 64'(32'h1234_5678));
    m_adr[63:32] = 32'h500; m_cyc[1] = 1'b1; m_stb[1] = 1'b1; stray_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wait_ack(1'b0, "t4_wait");
      chk($sformatf("t4_hold_%0d", b), 64'(grant), 64'(2'b01));
    end
    chk("t4_m1_ack", 64'(stray_ack), 64'(0));
    drop(1'b0); m_we = 2'b00;
    @(negedge clock);
    chk("t4_gap", 64'(grant), 64'(0));
    @(negedge clock);
    chk("t4_grant1", 64'(grant), 64'(2'b10));
    wait_ack(1'b1, "t4_wait1");
    drop(1'b1);
    @(negedge clock);

    // reset mid-transfer: leave last=0, then reset while m1 owns the bus
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clock);
    chk("t5_grant0", 64'(grant), 64'(2'b01));
    wait_ack(1'b0, "t5_wait0");
    drop(1'b0);
    @(negedge clock);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clock);
    chk("t5_grant1", 64'(grant), 64'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_cyc", 64'(s_cyc), 64'(0));
    chk("t5_async_stb", 64'(s_stb), 64'(0));
    chk("t5_async_grant", 64'(grant), 64'(0));
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("t5_after_rst", 64'(grant), 64'(2'b01));
    wait_ack(1'b0, "t5_wait_after");
    m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clock);
    chk("t5_idle", 64'(grant), 64'(0));

    // stalled slave
    slave_en = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clock);
    chk("t6_grant", 64'(grant), 64'(2'b01));
`ifdef WB_ARB_TIMEOUT_EN
    chk("t6_err_0", 64'(m_err), 64'(0));
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("t6_err_%0d", k), 64'(m_err), 64'(0));
    end
    @(negedge clock);
    chk("t6_err_pulse", 64'(m_err), 64'(2'b01));
    chk("t6_stb_forced", 64'(s_stb), 64'(0));
    chk("t6_no_ack", 64'(m_ack), 64'(0));
    @(negedge clock);
    chk("t6_err_clear", 64'(m_err), 64'(0));
    chk("t6_stb_back", 64'(s_stb), 64'(1));
    chk("t6_held", 64'(grant), 64'(2'b01));
`else
    repeat (20) @(negedge clock);
    chk("t6_no_err", 64'(m_err), 64'(0));
    chk("t6_stb_held", 64'(s_stb), 64'(1));
    chk("t6_held", 64'(grant), 64'(2'b01));
    chk("t6_no_ack", 64'(m_ack), 64'(0));
`endif
    drop(1'b0);
    @(negedge clock);
    chk("t6_release", 64'(grant), 64'(0));
    slave_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
